cpu_clock_ctrl: RTL and testbench

//  Consumes the slow divided clock from the divider stage and turns it into the CPU clock enable.

---
 rtl/clock_pkg.sv | 10 +
 rtl/button_debouncer.sv | 37 +++
 rtl/cpu_clock_ctrl.sv | 92 +++++++++
 tb/tb_cpu_clock_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// clock_pkg: state and mode encodings shared by the CPU clock controller
package clock_pkg;
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STEP   = 2'd1,
        ST_HALTED = 2'd2
    } state_t;
    localparam logic MODE_RUN  = 1'b0;
    localparam logic MODE_STEP = 1'b1;
endpackage

// File: rtl/button_debouncer.sv
// button_debouncer: accepts a new button level only after it has disagreed with the current one for DEBOUNCE_CYCLES cycles
module button_debouncer
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic btn_sync,
    output logic level,
    output logic rise
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    logic [CW-1:0] cnt;
    logic level_q;
    // count consecutive disagreeing cycles; any agreeing cycle restarts the count
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (btn_sync == level) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            level <= btn_sync;
            cnt   <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
    // previous accepted level for rising-edge detection
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) level_q <= 1'b0;
        else        level_q <= level;
    end
    assign rise = level & ~level_q;
endmodule

// File: rtl/cpu_clock_ctrl.sv
// cpu_clock_ctrl: turns the divided tick or a debounced step button into a single-cycle CPU clock enable
module cpu_clock_ctrl
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CLK_HIGH_CYCLES = 4
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic tick,
    input  logic step_btn,
    input  logic mode,
    input  logic hlt,
    output logic cpu_clk_en,
    output logic cpu_clk,
    output logic halted
);
    localparam int HW = $clog2(CLK_HIGH_CYCLES + 1);
    localparam logic [HW-1:0] HIGH_LOAD = HW'(CLK_HIGH_CYCLES - 1);
    logic [1:0] tick_s;
    logic [1:0] btn_s;
    logic [1:0] mode_s;
    logic tick_prev;
    logic run_edge;
    logic step_edge;
    logic unused_level;
    logic en_nx;
    logic [HW-1:0] high_cnt;
    state_t state;
    state_t state_nx;
    // two-flop synchronizers for the asynchronous inputs, plus tick history for edge detection
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            tick_s    <= '0;
            btn_s     <= '0;
            mode_s    <= '0;
            tick_prev <= 1'b0;
        end else begin
            tick_s    <= {tick_s[0], tick};
            btn_s     <= {btn_s[0], step_btn};
            mode_s    <= {mode_s[0], mode};
            tick_prev <= tick_s[1];
        end
    end
    assign run_edge = tick_s[1] & ~tick_prev;
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debouncer (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .btn_sync (btn_s[1]),
        .level    (unused_level),
        .rise     (step_edge)
    );
    // state, enable pulse and halt flag registers
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_RUN;
            cpu_clk_en <= 1'b0;
            halted     <= 1'b0;
        end else begin
            state      <= state_nx;
            cpu_clk_en <= en_nx;
            halted     <= state_nx == ST_HALTED;
        end
    end
    // next state and next enable; halting lets the current pulse stand but issues no more
    always_comb begin
        state_nx = state;
        en_nx    = 1'b0;
        case (state)
            ST_RUN: begin
                en_nx = run_edge & ~cpu_clk_en;
                if (cpu_clk_en && hlt)        state_nx = ST_HALTED;
                else if (mode_s[1] == MODE_STEP) state_nx = ST_STEP;
            end
            ST_STEP: begin
                en_nx = step_edge & ~cpu_clk_en;
                if (cpu_clk_en && hlt)       state_nx = ST_HALTED;
                else if (mode_s[1] == MODE_RUN) state_nx = ST_RUN;
            end
            ST_HALTED: state_nx = ST_HALTED;
            default:   state_nx = ST_RUN;
        endcase
        if (state_nx == ST_HALTED) en_nx = 1'b0;
    end
    // stretch each enable pulse to CLK_HIGH_CYCLES cycles for the LED; a new pulse reloads
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n)              high_cnt <= '0;
        else if (cpu_clk_en)     high_cnt <= HIGH_LOAD;
        else if (high_cnt != '0) high_cnt <= high_cnt - 1'b1;
    end
    assign cpu_clk = cpu_clk_en | (high_cnt != '0);
endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// tb_cpu_clock_ctrl: scoreboard bench for the CPU clock controller
module tb_cpu_clock_ctrl;
    logic clk_in = 1'b0;
    logic rst_n = 1'b0;
    logic tick = 1'b0;
    logic step_btn = 1'b0;
    logic mode = 1'b0;
    logic hlt = 1'b0;
    logic cpu_clk_en;
    logic cpu_clk;
    logic halted;
    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    int exp_q[$];
    int obs_q[$];

    cpu_clock_ctrl #(.DEBOUNCE_CYCLES(8), .CLK_HIGH_CYCLES(4)) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .tick       (tick),
        .step_btn   (step_btn),
        .mode       (mode),
        .hlt        (hlt),
        .cpu_clk_en (cpu_clk_en),
        .cpu_clk    (cpu_clk),
        .halted     (halted)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;
    always @(negedge clk_in) if (cpu_clk_en) obs_q.push_back(cyc);

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic tick_pulse(input bit expect_pulse, input int half);
        tick = 1'b1;
        if (expect_pulse) exp_q.push_back(cyc + 3);
        wait_n(half);
        tick = 1'b0;
        wait_n(half);
    endtask

    task automatic test_reset;
        wait_n(2);
        n_chk++;
        if ({cpu_clk_en, cpu_clk, halted} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, expected 000", {cpu_clk_en, cpu_clk, halted});
        end
        rst_n = 1'b1;
        wait_n(6);
        n_chk++;
        if ({cpu_clk_en, cpu_clk, halted} !== 3'b000) begin
            n_fail++;
            $display("FAIL idle_outputs: got %b, expected 000", {cpu_clk_en, cpu_clk, halted});
        end
    endtask

    task automatic test_run;
        int e, o, hi;
        mode = 1'b0;
        tick = 1'b1;
        exp_q.push_back(cyc + 3);
        wait_n(3);
        n_chk++;
        if (cpu_clk_en !== 1'b1) begin
            n_fail++;
            $display("FAIL run_latency: cpu_clk_en=%b, expected 1", cpu_clk_en);
        end
        hi = 0;
        for (int i = 0; i < 8; i++) begin
            if (cpu_clk) hi++;
            wait_n(1);
        end
        n_chk++;
        if (hi != 4) begin
            n_fail++;
            $display("FAIL run_stretch: cpu_clk high %0d cycles, expected 4", hi);
        end
        tick = 1'b0;
        wait_n(10);
        for (int i = 0; i < 3; i++) tick_pulse(1'b1, 10);
        wait_n(5);
        n_chk++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL run_count: got %0d pulses, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL run_cycle: pulse at cycle %0d, expected cycle %0d", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_step;
        int e, o;
        mode = 1'b1;
        wait_n(5);
        for (int i = 0; i < 3; i++) tick_pulse(1'b0, 10);
        for (int i = 0; i < 5; i++) begin
            step_btn = 1'b1;
            wait_n(2);
            step_btn = 1'b0;
            wait_n(2);
        end
        step_btn = 1'b1;
        exp_q.push_back(cyc + 11);
        wait_n(20);
        step_btn = 1'b0;
        wait_n(15);
        step_btn = 1'b1;
        wait_n(5);
        step_btn = 1'b0;
        wait_n(15);
        n_chk++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL step_count: got %0d pulses, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL step_cycle: pulse at cycle %0d, expected cycle %0d", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_halt;
        int e, o;
        mode = 1'b0;
        wait_n(5);
        tick_pulse(1'b1, 10);
        tick_pulse(1'b1, 10);
        tick = 1'b1;
        exp_q.push_back(cyc + 3);
        wait_n(3);
        n_chk++;
        if (cpu_clk_en !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_third_pulse: cpu_clk_en=%b, expected 1", cpu_clk_en);
        end
        hlt = 1'b1;
        wait_n(1);
        hlt = 1'b0;
        n_chk++;
        if (halted !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_flag: halted=%b, expected 1", halted);
        end
        tick = 1'b0;
        wait_n(10);
        for (int i = 0; i < 50; i++) begin
            step_btn = (i % 4) < 2;
            mode = (i % 3) == 0;
            tick_pulse(1'b0, 5);
        end
        step_btn = 1'b0;
        mode = 1'b0;
        wait_n(15);
        n_chk++;
        if (halted !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_sticky: halted=%b, expected 1", halted);
        end
        n_chk++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL halt_count: got %0d pulses, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL halt_cycle: pulse at cycle %0d, expected cycle %0d", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_async_reset;
        int e, o;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (halted !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_exits_halt: halted=%b, expected 0", halted);
        end
        @(negedge clk_in);
        rst_n = 1'b1;
        wait_n(5);
        tick = 1'b1;
        exp_q.push_back(cyc + 3);
        wait_n(3);
        n_chk++;
        if ({cpu_clk_en, cpu_clk} !== 2'b11) begin
            n_fail++;
            $display("FAIL pre_reset_pulse: en,clk=%b, expected 11", {cpu_clk_en, cpu_clk});
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({cpu_clk_en, cpu_clk, halted} !== 3'b000) begin
            n_fail++;
            $display("FAIL async_clear: got %b, expected 000", {cpu_clk_en, cpu_clk, halted});
        end
        @(negedge clk_in);
        tick = 1'b0;
        wait_n(2);
        rst_n = 1'b1;
        wait_n(5);
        tick_pulse(1'b1, 10);
        n_chk++;
        if (halted !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_halted: halted=%b, expected 0", halted);
        end
        n_chk++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL reset_count: got %0d pulses, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reset_cycle: pulse at cycle %0d, expected cycle %0d", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_mode_switch;
        int e, o;
        tick = 1'b1;
        mode = 1'b1;
        exp_q.push_back(cyc + 3);
        wait_n(10);
        tick = 1'b0;
        wait_n(10);
        for (int i = 0; i < 3; i++) tick_pulse(1'b0, 10);
        mode = 1'b0;
        wait_n(5);
        hlt = 1'b1;
        wait_n(1);
        hlt = 1'b0;
        wait_n(2);
        n_chk++;
        if (halted !== 1'b0) begin
            n_fail++;
            $display("FAIL hlt_without_enable: halted=%b, expected 0", halted);
        end
        step_btn = 1'b1;
        wait_n(20);
        step_btn = 1'b0;
        wait_n(15);
        tick_pulse(1'b1, 10);
        n_chk++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL mode_count: got %0d pulses, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL mode_cycle: pulse at cycle %0d, expected cycle %0d", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        @(negedge clk_in);
        test_reset();
        test_run();
        test_step();
        test_halt();
        test_async_reset();
        test_mode_switch();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
